// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle control FSM for the RV64 datapath. It fetches one 32-bit
// instruction over a req/ack handshake, decodes it, holds the ALU/regfile
// controls for one execute cycle, then writes back and advances the PC.
// Sequence: IDLE -> FETCH -> DECODE -> EXEC -> WB -> (FETCH | IDLE).
// A fetch that sees no ack within FETCH_TIMEOUT cycles is abandoned. The
// sticky fetch_err flag is set and the FSM returns to IDLE. The next start
// retries the fetch at the same PC.
//
// Only addi and add are legal. Any other instruction raises `illegal`.
//
// Optional feature (compile-time macro TRAP_ON_ILLEGAL_EN):
//   defined   : an illegal instruction sends DECODE -> HALT. HALT holds the PC
//               of the faulting instruction, keeps busy low, never retires,
//               and is left only through rst.
//   undefined : an illegal instruction runs as a NOP. There is no reg_write,
//               the instruction still retires, and the PC advances.
//
// Ports
//   clk         in   1     rising-edge clock
//   rst         in   1     asynchronous, active-high reset
//   start       in   1     run request, sampled in IDLE and WB
//   imem_req    out  1     fetch request, high for every FETCH cycle
//   imem_addr   out  XLEN  fetch address (the PC), stable while imem_req high
//   imem_ack    in   1     fetch complete; imem_rdata valid this cycle
//   imem_rdata  in   32    instruction word
//   alu_op      out  4     4'b0001 add, 4'b0000 none
//   immediate   out  1     ALU operand B: 1 = imm, 0 = rs2
//   reg_write   out  1     regfile write enable, one cycle in WB
//   rd/rs1/rs2  out  5     register fields of the latched instruction
//   imm         out  XLEN  I-type immediate, sign-extended
//   busy        out  1     high outside IDLE/HALT
//   retire      out  1     one-cycle pulse in WB
//   illegal     out  1     latched instruction is neither addi nor add
//   fetch_err   out  1     sticky fetch-timeout flag, cleared on next start
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int unsigned     XLEN          = 64,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int unsigned     FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [3:0]      alu_op,
  output logic            immediate,
  output logic            reg_write,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic            busy,
  output logic            retire,
  output logic            illegal,
  output logic            fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [3:0] ALU_NONE   = 4'b0000;
  localparam logic [3:0] ALU_ADD    = 4'b0001;

  // The counter only has to reach FETCH_TIMEOUT-1: the timeout fires in the
  // FETCH_TIMEOUT-th cycle rather than one cycle later.
  localparam int unsigned     CNT_W    = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_next;
  logic [CNT_W-1:0]  fetch_cnt;
  logic              dec_addi;
  logic              dec_add;

  // Decode straight from the incoming word so that the control outputs are
  // already valid during the DECODE cycle that follows the ack.
  assign dec_addi = (imem_rdata[6:0] == OPC_OP_IMM) && (imem_rdata[14:12] == 3'b000);
  assign dec_add  = (imem_rdata[6:0] == OPC_OP) && (imem_rdata[14:12] == 3'b000) &&
                    (imem_rdata[31:25] == 7'b0000000);

  // Natural modulo-2^XLEN wrap from 2^XLEN-4 to 0.
  assign pc_next = pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      fetch_cnt <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      alu_op    <= ALU_NONE;
      immediate <= 1'b0;
      reg_write <= 1'b0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      imm       <= '0;
      busy      <= 1'b0;
      retire    <= 1'b0;
      illegal   <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here make reg_write/retire single-cycle
      // pulses; a later assignment in the same pass simply overrides them.
      reg_write <= 1'b0;
      retire    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc;
            busy      <= 1'b1;
            fetch_err <= 1'b0;
          end
        end

        S_FETCH: begin
          // An ack in the timeout cycle is tested first, so it still succeeds.
          if (imem_ack) begin
            state     <= S_DECODE;
            imem_req  <= 1'b0;
            fetch_cnt <= '0;
            rd        <= imem_rdata[11:7];
            rs1       <= imem_rdata[19:15];
            rs2       <= imem_rdata[24:20];
            imm       <= {{(XLEN-12){imem_rdata[31]}}, imem_rdata[31:20]};
            if (dec_addi) begin
              alu_op    <= ALU_ADD;
              immediate <= 1'b1;
              illegal   <= 1'b0;
            end else if (dec_add) begin
              alu_op    <= ALU_ADD;
              immediate <= 1'b0;
              illegal   <= 1'b0;
            end else begin
              alu_op    <= ALU_NONE;
              immediate <= 1'b0;
              illegal   <= 1'b1;
            end
          end else if (fetch_cnt == CNT_LAST) begin
            state     <= S_IDLE;
            imem_req  <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b1;
            fetch_cnt <= '0;
          end else begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
          end
        end

        S_DECODE: begin
`ifdef TRAP_ON_ILLEGAL_EN
          if (illegal) begin
            state <= S_HALT;
            busy  <= 1'b0;
          end else begin
            state <= S_EXEC;
          end
`else
          state <= S_EXEC;
`endif
        end

        S_EXEC: begin
          // Writes to x0 are discarded, and illegal instructions behave as NOPs.
          state     <= S_WB;
          reg_write <= !illegal && (rd != 5'd0);
          retire    <= 1'b1;
        end

        S_WB: begin
          pc <= pc_next;
          if (start) begin
            state     <= S_FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc_next;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        S_HALT: begin
          // Left only through rst.
        end

        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Drives instruction fetches with random ack latency, random timeouts, and
// random gaps between fetches. It also randomizes the instruction mix. The
// bench keeps an instruction-level expectation of every DUT output: a scripted
// timeline derived from the fetch latency and the instruction word. A
// negedge process compares that expectation with the DUT outputs every cycle.
// Directed sequences at the start pin the model against hand-computed values.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam int          FT  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [3:0]  alu_op;
  logic        immediate;
  logic        reg_write;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] imm;
  logic        busy;
  logic        retire;
  logic        illegal;
  logic        fetch_err;

  instr_sequencer #(
    .XLEN(64),
    .RESET_PC(RPC),
    .FETCH_TIMEOUT(FT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .alu_op(alu_op),
    .immediate(immediate),
    .reg_write(reg_write),
    .rd(rd),
    .rs1(rs1),
    .rs2(rs2),
    .imm(imm),
    .busy(busy),
    .retire(retire),
    .illegal(illegal),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs.
  logic        e_req, e_rw, e_busy, e_ret, e_ill, e_err, e_isel, e_isel_known;
  logic [63:0] e_addr, e_imm;
  logic [3:0]  e_alu;
  logic [4:0]  e_rd, e_rs1, e_rs2;
  bit          chk_en = 1'b0;

  // Architectural view kept by the bench.
  logic [63:0] m_pc;
  bit          m_in_wb;
  bit          m_halted;

  // Per-instruction observations of the DUT for the directed checks.
  int          obs_req_cnt;
  int          obs_retire_at;
  logic [63:0] obs_fetch_addr;
  logic        obs_err_entry;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit is_addi(input logic [31:0] w);
    return (w[6:0] == 7'b0010011) && (w[14:12] == 3'b000);
  endfunction

  function automatic bit is_add(input logic [31:0] w);
    return (w[6:0] == 7'b0110011) && (w[14:12] == 3'b000) && (w[31:25] == 7'd0);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req",  imem_req,  e_req);
      check("imem_addr", imem_addr, e_addr);
      check("alu_op",    alu_op,    e_alu);
      if (e_isel_known) check("immediate", immediate, e_isel);
      check("reg_write", reg_write, e_rw);
      check("rd",        rd,        e_rd);
      check("rs1",       rs1,       e_rs1);
      check("rs2",       rs2,       e_rs2);
      check("imm",       imm,       e_imm);
      check("busy",      busy,      e_busy);
      check("retire",    retire,    e_ret);
      check("illegal",   illegal,   e_ill);
      check("fetch_err", fetch_err, e_err);
    end
  end

  task automatic reset_expect();
    e_req = 0; e_rw = 0; e_busy = 0; e_ret = 0; e_ill = 0; e_err = 0;
    e_isel = 0; e_isel_known = 1; e_addr = '0; e_imm = '0; e_alu = '0;
    e_rd = '0; e_rs1 = '0; e_rs2 = '0;
    m_pc = RPC; m_in_wb = 0; m_halted = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int cyc);
    if (imem_req) obs_req_cnt++;
    if (retire && obs_retire_at == 0) obs_retire_at = cyc;
    if (cyc == 1) begin
      obs_fetch_addr = imem_addr;
      obs_err_entry  = fetch_err;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    reset_expect();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Cycles with start low (or random start while halted): nothing may change.
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      start      = m_halted ? 1'($urandom) : 1'b0;
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      tick();
    end
  endtask

  // Leave WB with start low.
  task automatic go_idle();
    start = 1'b0;
    imem_ack = 1'($urandom);
    tick();
    m_pc = m_pc + 64'd4;
    e_busy = 0; e_rw = 0; e_ret = 0;
    m_in_wb = 0;
  endtask

  // One instruction from IDLE or WB. delay = ack cycle inside FETCH (1-based);
  // delay > FT means the memory never answers.
  task automatic do_instr(input logic [31:0] w, input int delay);
    int  cyc;
    bit  acked;
    bit  legal;
    legal = is_addi(w) || is_add(w);
    obs_req_cnt = 0;
    obs_retire_at = 0;
    start = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    tick();
    cyc = 1;
    sample(cyc);
    if (m_in_wb) m_pc = m_pc + 64'd4;
    m_in_wb = 0;
    e_req = 1; e_busy = 1; e_addr = m_pc; e_err = 0; e_rw = 0; e_ret = 0;

    acked = 0;
    for (int i = 1; i <= FT && !acked; i++) begin
      start      = 1'($urandom);
      imem_ack   = (i == delay);
      imem_rdata = (i == delay) ? w : $urandom;
      tick();
      cyc++;
      sample(cyc);
      if (i == delay) begin
        acked = 1;
        e_req = 0;
        e_rd = w[11:7]; e_rs1 = w[19:15]; e_rs2 = w[24:20];
        e_imm = 64'($signed(w[31:20]));
        e_alu = legal ? 4'd1 : 4'd0;
        e_ill = !legal;
        e_isel_known = legal;
        e_isel = is_addi(w);
      end else if (i == FT) begin
        e_req = 0; e_busy = 0; e_err = 1;
      end
    end
    if (!acked) begin
      start = 1'b0;
      return;
    end

    // DECODE -> EXEC (or HALT)
    start = 1'($urandom); imem_ack = 1'($urandom); imem_rdata = $urandom;
    tick();
    cyc++;
    sample(cyc);
`ifdef TRAP_ON_ILLEGAL_EN
    if (!legal) begin
      e_busy = 0;
      m_halted = 1;
      start = 1'b0;
      return;
    end
`endif

    // EXEC -> WB
    start = 1'($urandom); imem_ack = 1'($urandom); imem_rdata = $urandom;
    tick();
    cyc++;
    sample(cyc);
    e_rw = legal && (w[11:7] != 5'd0);
    e_ret = 1;
    m_in_wb = 1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0, 1: begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
      2:    begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = 7'd0; end
      3:    begin w[6:0] = ($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'b0010011; end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    reset_expect();
    #2;
    check("rst_req",  imem_req,  1'b0);
    check("rst_busy", busy,      1'b0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_err",  fetch_err, 1'b0);
    chk_en = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);

    // addi x1,x0,5 with single-cycle ack
    do_instr(32'h0050_0093, 1);
    check("t1_addr",    obs_fetch_addr, RPC);
    check("t1_imm",     imm,       64'd5);
    check("t1_rd",      rd,        5'd1);
    check("t1_alu",     alu_op,    4'd1);
    check("t1_immsel",  immediate, 1'b1);
    check("t1_rw",      reg_write, 1'b1);
    check("t1_retire",  obs_retire_at, 4);

    // add x3,x1,x2 with ack in the third FETCH cycle
    do_instr(32'h0020_81B3, 3);
    check("t2_addr",    obs_fetch_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t2_reqcyc",  obs_req_cnt, 3);
    check("t2_retire",  obs_retire_at, 6);
    check("t2_immsel",  immediate, 1'b0);
    check("t2_rs1",     rs1, 5'd1);
    check("t2_rs2",     rs2, 5'd2);
    check("t2_rd",      rd,  5'd3);

    // addi x1,x0,-1 fetched at the wrapped PC
    do_instr(32'hFFF0_0093, 2);
    check("t3_wrap",    obs_fetch_addr, 64'd0);
    check("t3_imm",     imm, 64'hFFFF_FFFF_FFFF_FFFF);

    // addi x0,x0,0: retires without a register write
    do_instr(32'h0000_0013, 1);
    check("t3_x0_rw",   reg_write, 1'b0);
    check("t3_x0_ret",  retire,    1'b1);
    go_idle();

    // fetch timeout at pc=8, then retry at the same pc
    do_instr(32'h0050_0093, FT + 1);
    check("t4_err",     fetch_err, 1'b1);
    check("t4_req",     imem_req,  1'b0);
    check("t4_busy",    busy,      1'b0);
    check("t4_reqcyc",  obs_req_cnt, FT);
    idle_cycles(3);
    check("t4_sticky",  fetch_err, 1'b1);
    do_instr(32'h0050_0093, 1);
    check("t4_retry",   obs_fetch_addr, 64'd8);
    check("t4_clear",   obs_err_entry, 1'b0);

    // all-zero word is illegal
    do_instr(32'h0000_0000, 1);
    check("t5_ill",     illegal, 1'b1);
    check("t5_alu",     alu_op,  4'd0);
`ifdef TRAP_ON_ILLEGAL_EN
    idle_cycles(4);
    check("t5_busy",    busy, 1'b0);
    check("t5_hold",    imem_addr, 64'd12);
    check("t5_noret",   retire, 1'b0);
    do_reset();
`else
    check("t5_rw",      reg_write, 1'b0);
    check("t5_ret",     retire, 1'b1);
    do_instr(32'h0050_0093, 1);
    check("t5_pcadv",   obs_fetch_addr, 64'h10);
    go_idle();
`endif

    // asynchronous reset in the middle of a fetch
    start = 1'b1; imem_ack = 1'b0;
    tick();
    e_req = 1; e_busy = 1; e_addr = m_pc; e_err = 0;
    check("t6_req_on",  imem_req, 1'b1);
    #2 rst = 1'b1;
    reset_expect();
    #1;
    check("t6_req_drop", imem_req,  1'b0);
    check("t6_busy",     busy,      1'b0);
    check("t6_addr",     imem_addr, 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    do_instr(32'h0050_0093, 1);
    check("t6_rpc",      obs_fetch_addr, RPC);

    // randomized run
    for (int n = 0; n < 250; n++) begin
      if (m_halted) do_reset();
      case ($urandom_range(0, 9))
        0:       d = FT + 1;
        1:       d = FT;
        default: d = $urandom_range(1, 4);
      endcase
      if (!m_in_wb && $urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
      do_instr(rand_instr(), d);
      if (m_in_wb && $urandom_range(0, 2) == 0) go_idle();
    end
    if (m_in_wb) go_idle();
    idle_cycles(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
